// File: rtl/quad_gate_tester.sv
// Functional tester for a quad 2-input logic chip: sweeps all 256 A/B vectors,
// compares the synchronized Y outputs against the selected gate function and
// accumulates a per-gate fail mask. Optional macro GATE_TESTER_FIRST_FAIL_EN
// adds first_fail_vec / first_fail_valid reporting of the first failing vector.
module quad_gate_tester #(
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic [2:0] gate_sel,
  input  logic [3:0] y_in,
  output logic [3:0] a_out,
  output logic [3:0] b_out,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] fail_mask
`ifdef GATE_TESTER_FIRST_FAIL_EN
  ,
  output logic [7:0] first_fail_vec,
  output logic       first_fail_valid
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    SAMPLE,
    DONE
  } state_t;

  typedef enum logic [2:0] {
    SEL_OR   = 3'd0,
    SEL_AND  = 3'd1,
    SEL_NAND = 3'd2,
    SEL_NOR  = 3'd3,
    SEL_XOR  = 3'd4
  } gate_t;

  // Settle counter counts down to zero, so it is loaded with one less than the hold time.
  localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);
  localparam logic [7:0] LAST_VEC    = 8'd255;

  state_t     state;
  logic [7:0] vec;
  logic [7:0] settle_cnt;
  logic [2:0] sel_q;
  logic [3:0] y_meta;
  logic [3:0] y_sync;
  logic [3:0] expected;
  logic [3:0] mismatch;
  logic [3:0] fail_next;
  logic [7:0] vec_inc;
  logic       start_accept;

  function automatic logic [3:0] gate_eval(input logic [2:0] sel,
                                           input logic [3:0] a,
                                           input logic [3:0] b);
    logic [3:0] r;
    r = '0;
    case (sel)
      SEL_OR:   r = a | b;
      SEL_AND:  r = a & b;
      SEL_NAND: r = ~(a & b);
      SEL_NOR:  r = ~(a | b);
      SEL_XOR:  r = a ^ b;
      default:  r = '0;
    endcase
    return r;
  endfunction

  // y_in comes straight off the chip pins with no relation to clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_meta <= '0;
      y_sync <= '0;
    end else begin
      y_meta <= y_in;
      y_sync <= y_meta;
    end
  end

  // The gate function is latched at start so a reserved gate_sel mid-run cannot corrupt it.
  assign expected     = gate_eval(sel_q, a_out, b_out);
  assign mismatch     = y_sync ^ expected;
  assign fail_next    = fail_mask | mismatch;
  assign vec_inc      = 8'(vec + 8'd1);
  assign start_accept = (state == IDLE) && start && !abort && (gate_sel <= 3'd4);

  // NOTE: every register here is assigned with <=, so each branch reads the values
  // from before the edge; blocking assignments would let later lines see updated state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      vec        <= '0;
      settle_cnt <= '0;
      sel_q      <= '0;
      a_out      <= '0;
      b_out      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      fail_mask  <= '0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        // fail_mask is kept so the partial run can still be inspected.
        state <= IDLE;
        busy  <= 1'b0;
        pass  <= 1'b0;
        a_out <= '0;
        b_out <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (start_accept) begin
              vec        <= '0;
              fail_mask  <= '0;
              pass       <= 1'b0;
              settle_cnt <= SETTLE_LOAD;
              sel_q      <= gate_sel;
              a_out      <= '0;
              b_out      <= '0;
              busy       <= 1'b1;
              state      <= SETTLE;
            end
          end
          SETTLE: begin
            if (settle_cnt == 8'd0) begin
              state <= SAMPLE;
            end else begin
              settle_cnt <= settle_cnt - 8'd1;
            end
          end
          SAMPLE: begin
            fail_mask <= fail_next;
            if (vec != LAST_VEC) begin
              vec        <= vec_inc;
              a_out      <= vec_inc[3:0];
              b_out      <= vec_inc[7:4];
              settle_cnt <= SETTLE_LOAD;
              state      <= SETTLE;
            end else begin
              // pass must include the final sample, which is still in flight in fail_next.
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (fail_next == 4'd0);
              a_out <= '0;
              b_out <= '0;
            end
          end
          DONE: begin
            state <= IDLE;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

`ifdef GATE_TESTER_FIRST_FAIL_EN
  logic sample_fire;

  assign sample_fire = (state == SAMPLE) && !abort;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      first_fail_vec   <= '0;
      first_fail_valid <= 1'b0;
    end else if (start_accept) begin
      first_fail_vec   <= '0;
      first_fail_valid <= 1'b0;
    end else if (sample_fire && (mismatch != 4'd0) && !first_fail_valid) begin
      first_fail_vec   <= vec;
      first_fail_valid <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_quad_gate_tester.sv
// Self-checking bench for quad_gate_tester: a chip model drives y_in, a run-level
// model predicts every output each cycle, and directed scenarios pin literal results.
module tb_quad_gate_tester;

  localparam int S   = 4;
  localparam int RUN = 256 * (S + 1);

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [2:0] gate_sel = 3'd0;
  logic [3:0] y_in;
  logic [3:0] a_out, b_out, fail_mask;
  logic       busy, done, pass;
  logic [7:0] first_fail_vec;
  logic       first_fail_valid;

  int n_tests = 0;
  int n_fail  = 0;
  int done_seen = 0;
  bit cmp_en = 1'b0;
  int chip_mode = 0;  // 0: ideal OR chip, 1: XOR chip with Y3 stuck at 0

  quad_gate_tester #(.SETTLE_CYCLES(S)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .abort    (abort),
    .gate_sel (gate_sel),
    .y_in     (y_in),
    .a_out    (a_out),
    .b_out    (b_out),
    .busy     (busy),
    .done     (done),
    .pass     (pass),
    .fail_mask(fail_mask)
`ifdef GATE_TESTER_FIRST_FAIL_EN
    ,
    .first_fail_vec  (first_fail_vec),
    .first_fail_valid(first_fail_valid)
`endif
  );

`ifndef GATE_TESTER_FIRST_FAIL_EN
  assign first_fail_vec   = '0;
  assign first_fail_valid = 1'b0;
`endif

  always #5 clk = ~clk;

  function automatic logic [3:0] chip(input int mode, input logic [3:0] a, input logic [3:0] b);
    if (mode == 0) return a | b;
    return (a ^ b) & 4'b1011;
  endfunction

  function automatic logic [3:0] spec_f(input logic [2:0] sel, input logic [3:0] a, input logic [3:0] b);
    case (sel)
      3'd0:    return a | b;
      3'd1:    return a & b;
      3'd2:    return ~(a & b);
      3'd3:    return ~(a | b);
      3'd4:    return a ^ b;
      default: return 4'd0;
    endcase
  endfunction

  always_comb y_in = chip(chip_mode, a_out, b_out);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Run-level model: m_t counts clock edges since the start-capture edge.
  logic       m_active = 1'b0, m_done = 1'b0, m_pass = 1'b0, m_ffvalid = 1'b0;
  logic [3:0] m_mask = '0;
  logic [7:0] m_ffvec = '0;
  logic [2:0] m_sel = '0;
  int         m_t = 0;

  always @(posedge clk or posedge rst) begin : model
    logic [7:0] v;
    logic [3:0] mm;
    int         t1;
    if (rst) begin
      m_active <= 1'b0; m_done <= 1'b0; m_pass <= 1'b0; m_mask <= '0;
      m_ffvalid <= 1'b0; m_ffvec <= '0; m_t <= 0;
    end else if (abort) begin
      m_active <= 1'b0; m_done <= 1'b0; m_pass <= 1'b0;
    end else if (m_active) begin
      t1 = m_t + 1;
      v  = 8'(m_t / (S + 1));
      mm = '0;
      if (m_t % (S + 1) == S) mm = chip(chip_mode, v[3:0], v[7:4]) ^ spec_f(m_sel, v[3:0], v[7:4]);
      m_mask <= m_mask | mm;
      if (mm != 4'd0 && !m_ffvalid) begin
        m_ffvec   <= v;
        m_ffvalid <= 1'b1;
      end
      m_t <= t1;
      if (t1 == RUN) begin
        m_active <= 1'b0;
        m_done   <= 1'b1;
        m_pass   <= ((m_mask | mm) == 4'd0);
      end
    end else if (m_done) begin
      m_done <= 1'b0;
    end else if (start && gate_sel <= 3'd4) begin
      m_active <= 1'b1; m_t <= 0; m_mask <= '0; m_pass <= 1'b0;
      m_ffvalid <= 1'b0; m_ffvec <= '0; m_sel <= gate_sel;
    end
  end

  always @(negedge clk) begin : compare
    logic [7:0] vexp;
    vexp = m_active ? 8'(m_t / (S + 1)) : 8'd0;
    if (done === 1'b1) done_seen++;
    if (cmp_en) begin
      check("busy", busy, m_active);
      check("done", done, m_done);
      check("pass", pass, m_pass);
      check("fail_mask", fail_mask, m_mask);
      check("a_out", a_out, vexp[3:0]);
      check("b_out", b_out, vexp[7:4]);
`ifdef GATE_TESTER_FIRST_FAIL_EN
      check("first_fail_valid", first_fail_valid, m_ffvalid);
      check("first_fail_vec", first_fail_vec, m_ffvec);
`endif
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_start(input logic [2:0] sel);
    gate_sel = sel;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (done !== 1'b1 && n < RUN + 20) begin
      step();
      n++;
    end
    if (done !== 1'b1) check("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_case(input string name, input int mode, input logic [2:0] sel,
                          input logic exp_pass, input logic [3:0] exp_mask,
                          input logic [7:0] exp_ffvec);
    int n;
    chip_mode = mode;
    do_start(sel);
    wait_done(n);
    check({name, "_latency"}, n, RUN);
    check({name, "_pass"}, pass, exp_pass);
    check({name, "_mask"}, fail_mask, exp_mask);
`ifdef GATE_TESTER_FIRST_FAIL_EN
    check({name, "_ffvalid"}, first_fail_valid, (exp_mask != 4'd0));
    check({name, "_ffvec"}, first_fail_vec, exp_ffvec);
`else
    if (exp_ffvec != 8'd0) check({name, "_ffvec_unused"}, 32'd0, 32'd0 + first_fail_vec);
`endif
    step();
  endtask

  initial begin
    int n, d0;
    repeat (3) step();
    cmp_en = 1'b1;
    check("rst_busy", busy, 1'b0);
    check("rst_outs", {a_out, b_out, fail_mask, done, pass}, 14'd0);
    rst = 1'b0;
    step();

    run_case("or_ok", 0, 3'd0, 1'b1, 4'b0000, 8'h00);
    run_case("and_vs_or", 0, 3'd1, 1'b0, 4'b1111, 8'h01);
    run_case("xor_y3_stuck", 1, 3'd4, 1'b0, 4'b0100, 8'h04);

    // Abort at cycle 500 of an XOR run with a stuck Y3.
    chip_mode = 1;
    d0 = done_seen;
    do_start(3'd4);
    repeat (500) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_busy", busy, 1'b0);
    check("abort_ab", {a_out, b_out}, 8'd0);
    check("abort_pass", pass, 1'b0);
    check("abort_mask_kept", fail_mask, 4'b0100);
    repeat (RUN + 100) step();
    check("abort_no_done", done_seen, d0);

    // Reset mid-run, then a clean run.
    chip_mode = 0;
    d0 = done_seen;
    do_start(3'd0);
    repeat (300) step();
    rst = 1'b1;
    repeat (3) begin
      step();
      check("rst_mid_outs", {busy, done, pass, fail_mask, a_out, b_out}, 15'd0);
    end
    rst = 1'b0;
    step();
    check("rst_mid_no_done", done_seen, d0);
    run_case("after_rst", 0, 3'd0, 1'b1, 4'b0000, 8'h00);

    // start held for the whole run yields exactly one run.
    d0 = done_seen;
    gate_sel = 3'd0;
    start = 1'b1;
    step();
    wait_done(n);
    start = 1'b0;
    check("held_latency", n, RUN);
    repeat (30) step();
    check("held_one_done", done_seen, d0 + 1);
    check("held_idle", busy, 1'b0);

    // Reserved gate_sel is refused.
    d0 = done_seen;
    gate_sel = 3'd6;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (5) begin
      step();
      check("sel6_busy", busy, 1'b0);
    end
    check("sel6_pass_kept", pass, 1'b1);
    check("sel6_no_done", done_seen, d0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/quad_gate_tester.md
QUAD_GATE_TESTER -- requirements
Module: quad_gate_tester

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 4, meaning clock cycles the tester holds each vector before sampling; legal range 3..255.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset; asynchronous, active-high.
REQ-004 SHALL have port start, input, 1, single-cycle request to begin a test run.
REQ-005 SHALL have port abort, input, 1, terminates a run in progress.
REQ-006 SHALL have port gate_sel, input, 3, expected function: 0 OR, 1 AND, 2 NAND, 3 NOR, 4 XOR; 5-7 reserved.
REQ-007 SHALL have port y_in, input, 4, outputs Y1..Y4 of the quad 2-input chip under test; asynchronous to clk.
REQ-008 SHALL have port a_out, output, 4, drives A1..A4 of the chip under test.
REQ-009 SHALL have port b_out, output, 4, drives B1..B4 of the chip under test.
REQ-010 SHALL have port busy, output, 1, high while a run is active.
REQ-011 SHALL have port done, output, 1, one-cycle pulse at normal run completion.
REQ-012 SHALL have port pass, output, 1, result of the last completed run.
REQ-013 SHALL have port fail_mask, output, 4, bit i set if gate i+1 mismatched in any vector of the current or last run.

Function
REQ-014 SHALL implement states IDLE, SETTLE, SAMPLE, DONE.
REQ-015 SHALL, in IDLE with start=1 and gate_sel<=4, at that edge: clear the 8-bit vector counter vec to 0, clear fail_mask, clear pass, load the settle counter, enter SETTLE.
REQ-016 SHALL ignore start while busy, and ignore start with gate_sel>4 (remains IDLE, outputs unchanged).
REQ-017 SHALL drive a_out=vec[3:0] and b_out=vec[7:4] registered, for all 256 vectors, and drive 0 on both in IDLE and DONE.
REQ-018 SHALL pass y_in through a two-flop synchronizer before comparison.
REQ-019 SHALL remain in SETTLE for exactly SETTLE_CYCLES cycles, then spend one cycle in SAMPLE.
REQ-020 SHALL, in SAMPLE, compute expected[i] = f(a_out[i], b_out[i]) for gate_sel and OR (synchronized y_in XOR expected) into fail_mask.
REQ-021 SHALL, leaving SAMPLE, enter SETTLE with vec+1 if vec<255, else enter DONE.
REQ-022 SHALL, in DONE, assert done for one cycle, set pass = (fail_mask==0) including the final sample, then return to IDLE.
REQ-023 SHALL raise done exactly 256*(SETTLE_CYCLES+1) cycles after the start-capture edge.
REQ-024 SHALL assert busy in SETTLE and SAMPLE only.
REQ-025 SHALL, on abort=1 in any state, go to IDLE next edge with done=0, pass=0, fail_mask retained; abort has priority over start in the same cycle.
REQ-026 SHALL hold pass and fail_mask stable in IDLE until the next accepted start.

Reset
REQ-027 SHALL, on rst, immediately force IDLE, vec=0, a_out=0, b_out=0, busy=0, done=0, pass=0, fail_mask=0, synchronizer flops=0.
REQ-028 SHALL, when rst asserts mid-run, discard the run with no done pulse.

Configuration
REQ-029 SHALL, with macro GATE_TESTER_FIRST_FAIL_EN defined, add outputs first_fail_vec (8) and first_fail_valid (1): captured vec of the first mismatching SAMPLE of a run, valid set at that edge; both cleared by accepted start and by reset.
REQ-030 SHALL, without GATE_TESTER_FIRST_FAIL_EN, omit both ports and their logic; all other behaviour identical.

Verification
REQ-031 SHALL cover: gate_sel=0, ideal OR model on y_in, SETTLE_CYCLES=4, start -> done at cycle 1280, pass=1, fail_mask=0000.
REQ-032 SHALL cover: gate_sel=1 with OR model attached -> pass=0, fail_mask=1111; with macro, first_fail_vec=0x01, first_fail_valid=1.
REQ-033 SHALL cover: XOR model with Y3 stuck at 0, gate_sel=4 -> pass=0, fail_mask=0100; with macro, first_fail_vec=0x04.
REQ-034 SHALL cover: abort asserted at cycle 500 -> busy=0 next cycle, no done pulse, a_out=b_out=0, pass=0.
REQ-035 SHALL cover: rst pulsed mid-run, start again -> all outputs 0 during rst; second run completes in 1280 cycles with pass=1.
REQ-036 SHALL cover: start held high for the whole run and start with gate_sel=6 -> exactly one run, one done pulse; gate_sel=6 start leaves busy=0.
